gray_ise_sequencer: RTL
=======================

Name: gray_ise_sequencer

Overview:
Multi-cycle custom-instruction unit that converts RGB565 pixels to 8-bit grayscale.
- Uses one shared multiply-accumulate datapath, sequenced by an FSM: one channel per cycle.
- Converts one or two pixels per instruction.
- Holds the channel weights in a register bank.
- Sits on the processor custom-instruction port beside the other ISE modules and answers only to its own iseId.

Parameters:
- customId, 8'h0: ISE identifier this block responds to.
- DEF_WR, 8'd54: reset value of the red weight.
- DEF_WG, 8'd183: reset value of the green weight.
- DEF_WB, 8'd19: reset value of the blue weight.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle instruction strobe.
- iseId  in  8  instruction identifier; compared with customId.
- valueA  in  32  operand: pixel data, or weight data for op 2.
- valueB  in  32  operation select in [1:0]; bits [31:2] are ignored.
- done  out  1  single-cycle completion pulse.
- result  out  32  result; valid only while done=1, otherwise 32'h0.

Behaviour:
- Reset (asynchronous on reset_n=0):
  - FSM goes to IDLE; done=0; result=0.
  - Accumulator and pixel latches are cleared.
  - Weights take DEF_WR/DEF_WG/DEF_WB.
  - Asserting reset mid-operation aborts the operation; no done is issued.
- Accept: start=1 with iseId==customId while in IDLE. In the accept cycle (cycle 0) latch valueA and op=valueB[1:0].
- Ignore: start with a non-matching iseId, and any start while not in IDLE (no queueing, no done).
- Ops:
  - 0 (PIX1): convert valueA[15:0].
  - 1 (PIX2): convert lo=valueA[15:0], then hi=valueA[31:16].
  - 2 (WSET): wr=valueA[7:0], wg=valueA[15:8], wb=valueA[23:16].
  - 3 (WGET): result={8'h0, wb, wg, wr}.
- FSM states: IDLE, MAC_R, MAC_G, MAC_B, EMIT, DONE.
  - PIX1: IDLE->MAC_R->MAC_G->MAC_B->DONE.
  - PIX2: after the first MAC_B go to EMIT. EMIT stores gray_lo, clears acc, selects the hi pixel, then MAC_R for the second pixel.
  - WSET/WGET: IDLE->DONE.
  - DONE lasts one cycle and asserts done; next state is IDLE.
- Datapath:
  - Channels: r=px[15:11] (5b), g=px[10:5] (6b), b=px[4:0] (5b), all zero-extended.
  - One 8x8 multiplier; acc is 16 bits: acc += ch*w per MAC state. acc is cleared on accept.
  - gray = acc[15:8] (floor of acc/256). Max sum is 31875, so there is no overflow.
- Latency (accept = cycle 0; done high in cycle N):
  - PIX1: N=4.
  - PIX2: N=8.
  - WSET/WGET: N=1.
- Result formats:
  - PIX1: {24'h0, gray}.
  - PIX2: {16'h0, gray_hi, gray_lo}.
  - WSET: 32'h0.
- A start that arrives in the same cycle as done is ignored, because the FSM is not yet in IDLE. A new instruction is accepted from cycle N+1 onward.

Optional Feature:
GRAY_ISE_WEIGHT_CFG_EN
- Defined: op 2 writes the weight registers as above.
- Undefined:
  - Weights are constants DEF_*, with no weight flops.
  - Op 2 completes at N=1 with result 32'h0 and has no effect.
  - Op 3 still returns the constants.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, then 1 → done=0, result=0. WGET → result=32'h0013B736.
- PIX1 on valueA=32'h0000FFFF, default weights → done in cycle 4, result=32'h00000035. Pixel 0x0000 → 0. Pixel 0xF800 → 32'h00000006.
- PIX2 on valueA=32'h07E0F800 → done in cycle 8, result=32'h00002D06. done is high for exactly one cycle, and result is 0 in the cycles before and after.
- WSET valueA=32'h0000FFFF (wr=255, wg=255, wb=0), then PIX1 0xFFFF → result=32'h0000005D. With the macro undefined, the same sequence → result=32'h00000035.
- Ignore rules:
  - Mismatched iseId with start → no done.
  - Second start in cycle 2 of a PIX1 → single done in cycle 4 with the first instruction's result.
  - Start coincident with done → ignored.
- Reset mid-PIX2 (reset_n low in cycle 5) → no done. A following PIX1 of 0xFFFF with weights previously written → result uses the default weights (32'h00000035).

Source files
------------

// File: rtl/gray_ise_sequencer_if.sv
// Custom-instruction port bundle for gray_ise_sequencer.
//   start  : single-cycle instruction strobe (processor -> ISE)
//   iseId  : instruction identifier (processor -> ISE)
//   valueA : operand A, pixel or weight data (processor -> ISE)
//   valueB : operand B, op select in [1:0] (processor -> ISE)
//   done   : single-cycle completion pulse (ISE -> processor)
//   result : result word, zero unless done (ISE -> processor)
interface gray_ise_sequencer_if;
   localparam int unsigned ID_W   = 8;
   localparam int unsigned DATA_W = 32;

   logic              start;
   logic [ID_W-1:0]   iseId;
   logic [DATA_W-1:0] valueA;
   logic [DATA_W-1:0] valueB;
   logic              done;
   logic [DATA_W-1:0] result;

   modport master (output start, iseId, valueA, valueB, input done, result);
   modport slave  (input start, iseId, valueA, valueB, output done, result);
endinterface

// File: rtl/gray_ise_sequencer.sv
// RGB565 -> 8-bit grayscale custom-instruction unit. A single 8x8 MAC is
// time-shared across the R, G and B channels by a small FSM; one or two
// pixels per instruction. Channel weights live in a small register bank.
//
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : custom-instruction port (slave side of gray_ise_sequencer_if)
//
// Ops (valueB[1:0]): 0 PIX1, 1 PIX2, 2 WSET, 3 WGET.
//
// Optional feature macro: GRAY_ISE_WEIGHT_CFG_EN
//   defined   : WSET writes the weight registers
//   undefined : weights are the DEF_* constants; WSET completes with no effect
module gray_ise_sequencer #(
   parameter logic [7:0] customId = 8'h0,
   parameter logic [7:0] DEF_WR   = 8'd54,
   parameter logic [7:0] DEF_WG   = 8'd183,
   parameter logic [7:0] DEF_WB   = 8'd19
) (
   input logic                  clock,
   input logic                  reset_n,
   gray_ise_sequencer_if.slave  bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PIX_W  = 16;
   localparam int unsigned W_W    = 8;
   localparam int unsigned ACC_W  = 16;

   localparam logic [1:0] OP_PIX1 = 2'd0;
   localparam logic [1:0] OP_PIX2 = 2'd1;
   localparam logic [1:0] OP_WSET = 2'd2;
   localparam logic [1:0] OP_WGET = 2'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC_R = 3'd1,
      MAC_G = 3'd2,
      MAC_B = 3'd3,
      EMIT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state_q, state_nxt;
   logic [DATA_W-1:0]   px_q;
   logic [1:0]          op_q;
   logic                hi_q;
   logic [ACC_W-1:0]    acc_q, acc_nxt;
   logic [W_W-1:0]      gray_lo_q;
   logic                done_q;
   logic [DATA_W-1:0]   result_q;

   logic [W_W-1:0]      wr, wg, wb;
   logic                accept_c;
   logic [1:0]          op_c;
   logic [PIX_W-1:0]    px_c;
   logic [W_W-1:0]      ch_c, w_c;
   logic [ACC_W-1:0]    prod_c;
   logic [DATA_W-1:0]   result_c;
   logic                unused_vb;

   assign unused_vb = ^bus.valueB[DATA_W-1:2];

   assign accept_c = bus.start && (bus.iseId == customId) && (state_q == IDLE);
   // Op in flight: live operand in the accept cycle, latched copy afterwards.
   assign op_c     = (state_q == IDLE) ? bus.valueB[1:0] : op_q;

`ifdef GRAY_ISE_WEIGHT_CFG_EN
   logic [W_W-1:0] wr_q, wg_q, wb_q;

   // Weight bank, written on WSET accept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= DEF_WR;
         wg_q <= DEF_WG;
         wb_q <= DEF_WB;
      end else if (accept_c && (bus.valueB[1:0] == OP_WSET)) begin
         wr_q <= bus.valueA[7:0];
         wg_q <= bus.valueA[15:8];
         wb_q <= bus.valueA[23:16];
      end
   end

   assign wr = wr_q;
   assign wg = wg_q;
   assign wb = wb_q;
`else
   assign wr = DEF_WR;
   assign wg = DEF_WG;
   assign wb = DEF_WB;
`endif

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_nxt = ((op_c == OP_PIX1) || (op_c == OP_PIX2)) ? MAC_R : DONE;
            end
         end
         MAC_R:   state_nxt = MAC_G;
         MAC_G:   state_nxt = MAC_B;
         MAC_B:   state_nxt = ((op_q == OP_PIX2) && !hi_q) ? EMIT : DONE;
         EMIT:    state_nxt = MAC_R;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shared MAC: channel/weight mux, one multiply, accumulate.
   always_comb begin
      px_c    = hi_q ? px_q[31:16] : px_q[15:0];
      ch_c    = '0;
      w_c     = '0;
      acc_nxt = acc_q;
      case (state_q)
         MAC_R: begin ch_c = W_W'(px_c[15:11]); w_c = wr; end
         MAC_G: begin ch_c = W_W'(px_c[10:5]);  w_c = wg; end
         MAC_B: begin ch_c = W_W'(px_c[4:0]);   w_c = wb; end
         default: ;
      endcase
      prod_c = ACC_W'(ch_c) * ACC_W'(w_c);
      if ((state_q == MAC_R) || (state_q == MAC_G) || (state_q == MAC_B)) begin
         acc_nxt = acc_q + prod_c;
      end
      if (accept_c || (state_q == EMIT)) begin
         acc_nxt = '0;
      end
   end

   // Result word for the cycle that enters DONE; zero at all other times.
   always_comb begin
      result_c = '0;
      if (state_nxt == DONE) begin
         case (op_c)
            OP_PIX1: result_c = {24'h0, acc_nxt[15:8]};
            OP_PIX2: result_c = {16'h0, acc_nxt[15:8], gray_lo_q};
            OP_WSET: result_c = '0;
            OP_WGET: result_c = {8'h0, wb, wg, wr};
            default: result_c = '0;
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         px_q      <= '0;
         op_q      <= '0;
         hi_q      <= 1'b0;
         acc_q     <= '0;
         gray_lo_q <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q  <= state_nxt;
         acc_q    <= acc_nxt;
         done_q   <= (state_nxt == DONE);
         result_q <= result_c;
         if (accept_c) begin
            px_q <= bus.valueA;
            op_q <= bus.valueB[1:0];
            hi_q <= 1'b0;
         end
         // Low pixel finished: park its gray value and switch to the high pixel.
         if (state_q == EMIT) begin
            gray_lo_q <= acc_q[15:8];
            hi_q      <= 1'b1;
         end
      end
   end

   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
